uart_cmd_ctrl: RTL and testbench

//  Frame controller behind the UartRx receiver in the top_rx design.

---
 rtl/uart_cmd_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// uart_cmd_ctrl
// Frame controller behind the UART receiver. Parses 4-byte command frames
// (SYNC, CMD, DATA, CHK), applies valid commands to the LED register and
// reports checksum / unknown-command / inter-byte-timeout errors.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   i_rx_dv     1-cycle strobe, i_rx_byte valid
//   i_rx_byte   received byte
//   led         LED register
//   o_cmd_done  1-cycle pulse, valid command applied
//   o_err       1-cycle pulse, frame dropped (bad chk, bad cmd, timeout)
//   o_timeout   1-cycle pulse, frame dropped by timeout (o_err also high)
//   o_err_cnt   saturating count of o_err pulses
//   o_busy      high whenever the parser is not idle
// -----------------------------------------------------------------------------
module uart_cmd_ctrl #(
   parameter logic [7:0] SYNC_BYTE      = 8'hA5,
   parameter int         TIMEOUT_CYCLES = 4160,
   parameter int         CNT_W          = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_rx_dv,
   input  logic [7:0]       i_rx_byte,
   output logic [7:0]       led,
   output logic             o_cmd_done,
   output logic             o_err,
   output logic             o_timeout,
   output logic [CNT_W-1:0] o_err_cnt,
   output logic             o_busy
);

   localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES - 1);

   localparam logic [7:0] CMD_WRITE  = 8'h01;
   localparam logic [7:0] CMD_SET    = 8'h02;
   localparam logic [7:0] CMD_CLR    = 8'h03;
   localparam logic [7:0] CMD_TOGGLE = 8'h04;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      GET_CMD  = 3'd1,
      GET_DATA = 3'd2,
      GET_CHK  = 3'd3,
      EXEC     = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [7:0]       cmd_q, cmd_d;
   logic [7:0]       data_q, data_d;
   logic [7:0]       chk_q, chk_d;
   logic [7:0]       led_q, led_d;
   logic             cmd_done_q, cmd_done_d;
   logic             err_q, err_d;
   logic             timeout_q, timeout_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic             busy_q, busy_d;

   logic             in_frame;
   logic             timeout_hit;

   // A byte arriving in the same cycle as the limit takes priority.
   assign in_frame    = (state_q == GET_CMD) || (state_q == GET_DATA) || (state_q == GET_CHK);
   assign timeout_hit = in_frame && !i_rx_dv && (tmr_q == TMR_LIMIT);

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         tmr_q      <= '0;
         cmd_q      <= '0;
         data_q     <= '0;
         chk_q      <= '0;
         led_q      <= '0;
         cmd_done_q <= 1'b0;
         err_q      <= 1'b0;
         timeout_q  <= 1'b0;
         err_cnt_q  <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tmr_q      <= tmr_d;
         cmd_q      <= cmd_d;
         data_q     <= data_d;
         chk_q      <= chk_d;
         led_q      <= led_d;
         cmd_done_q <= cmd_done_d;
         err_q      <= err_d;
         timeout_q  <= timeout_d;
         err_cnt_q  <= err_cnt_d;
         busy_q     <= busy_d;
      end
   end

   // Next-state and inter-byte timer
   always_comb begin
      state_d = state_q;
      tmr_d   = '0;
      case (state_q)
         IDLE: begin
            if (i_rx_dv && (i_rx_byte == SYNC_BYTE)) state_d = GET_CMD;
         end
         GET_CMD, GET_DATA, GET_CHK: begin
            if (i_rx_dv) begin
               case (state_q)
                  GET_CMD:  state_d = GET_DATA;
                  GET_DATA: state_d = GET_CHK;
                  default:  state_d = EXEC;
               endcase
            end else if (timeout_hit) begin
               state_d = IDLE;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         EXEC:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Field capture, command execution and status outputs
   always_comb begin
      cmd_d      = cmd_q;
      data_d     = data_q;
      chk_d      = chk_q;
      led_d      = led_q;
      cmd_done_d = 1'b0;
      err_d      = 1'b0;
      timeout_d  = 1'b0;
      err_cnt_d  = err_cnt_q;

      if (i_rx_dv) begin
         case (state_q)
            GET_CMD:  cmd_d  = i_rx_byte;
            GET_DATA: data_d = i_rx_byte;
            GET_CHK:  chk_d  = i_rx_byte;
            default:  ;
         endcase
      end

      if (state_q == EXEC) begin
         if (chk_q == (cmd_q ^ data_q)) begin
            cmd_done_d = 1'b1;
            case (cmd_q)
               CMD_WRITE:  led_d = data_q;
               CMD_SET:    led_d = led_q | data_q;
               CMD_CLR:    led_d = led_q & ~data_q;
               CMD_TOGGLE: led_d = led_q ^ data_q;
               default: begin
                  cmd_done_d = 1'b0;
                  err_d      = 1'b1;
               end
            endcase
         end else begin
            err_d = 1'b1;
         end
      end

      if (timeout_hit) begin
         timeout_d = 1'b1;
         err_d     = 1'b1;
      end

      // Saturate rather than wrap so a long run of errors stays visible.
      if (err_d && (err_cnt_q != {CNT_W{1'b1}})) err_cnt_d = err_cnt_q + CNT_W'(1);

      busy_d = (state_d != IDLE);
   end

   assign led        = led_q;
   assign o_cmd_done = cmd_done_q;
   assign o_err      = err_q;
   assign o_timeout  = timeout_q;
   assign o_err_cnt  = err_cnt_q;
   assign o_busy     = busy_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
module tb_uart_cmd_ctrl;

   localparam logic [7:0] SYNC = 8'hA5;
   localparam int         TMO  = 4160;

   logic       clk = 1'b0;
   logic       rst;
   logic       i_rx_dv;
   logic [7:0] i_rx_byte;
   logic [7:0] led;
   logic       o_cmd_done, o_err, o_timeout, o_busy;
   logic [7:0] o_err_cnt;

   uart_cmd_ctrl #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .i_rx_dv(i_rx_dv), .i_rx_byte(i_rx_byte),
      .led(led), .o_cmd_done(o_cmd_done), .o_err(o_err), .o_timeout(o_timeout),
      .o_err_cnt(o_err_cnt), .o_busy(o_busy)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // pulse monitor
   int obs_done = 0, obs_err = 0, obs_to = 0, obs_to_alone = 0;
   always @(negedge clk) begin
      if (o_cmd_done === 1'b1) obs_done++;
      if (o_err === 1'b1) obs_err++;
      if (o_timeout === 1'b1) obs_to++;
      if (o_timeout === 1'b1 && o_err !== 1'b1) obs_to_alone++;
   end

   // reference model: frame position and expected results
   int         pos = 0;
   logic [7:0] m_cmd, m_data;
   logic [7:0] m_led = 8'h00;
   int         m_cnt = 0;
   int         exp_done = 0, exp_err = 0, exp_to = 0;

   function automatic void model_err();
      exp_err++;
      if (m_cnt < 255) m_cnt++;
   endfunction

   function automatic void model_byte(input logic [7:0] b);
      if (pos == 0) begin
         if (b == SYNC) pos = 1;
      end else if (pos == 1) begin
         m_cmd = b; pos = 2;
      end else if (pos == 2) begin
         m_data = b; pos = 3;
      end else begin
         pos = 0;
         if (b == (m_cmd ^ m_data) && m_cmd >= 8'd1 && m_cmd <= 8'd4) begin
            exp_done++;
            if (m_cmd == 8'd1) m_led = m_data;
            else if (m_cmd == 8'd2) m_led = m_led | m_data;
            else if (m_cmd == 8'd3) m_led = m_led & ~m_data;
            else m_led = m_led ^ m_data;
         end else begin
            model_err();
         end
      end
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".led"}, {24'h0, led}, {24'h0, m_led});
      chk({tag, ".err_cnt"}, {24'h0, o_err_cnt}, m_cnt);
      chk({tag, ".done_pulses"}, obs_done, exp_done);
      chk({tag, ".err_pulses"}, obs_err, exp_err);
      chk({tag, ".to_pulses"}, obs_to, exp_to);
      chk({tag, ".busy"}, {31'h0, o_busy}, {31'h0, (pos != 0)});
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      @(negedge clk);
      i_rx_dv = 1'b1;
      i_rx_byte = b;
      @(negedge clk);
      i_rx_dv = 1'b0;
      i_rx_byte = $urandom_range(0, 255);
      repeat (gap) @(negedge clk);
      model_byte(b);
   endtask

   task automatic frame(input logic [7:0] c, input logic [7:0] d, input logic [7:0] k);
      send(SYNC, 3); send(c, 3); send(d, 3); send(k, 4);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int waited;
      logic [7:0] c, d, k, g;
      rst = 1'b1; i_rx_dv = 1'b0; i_rx_byte = 8'h00;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst.led", {24'h0, led}, 32'h0);
      chk("rst.done", {31'h0, o_cmd_done}, 32'h0);
      chk("rst.err", {31'h0, o_err}, 32'h0);
      chk("rst.timeout", {31'h0, o_timeout}, 32'h0);
      chk("rst.busy", {31'h0, o_busy}, 32'h0);
      chk("rst.err_cnt", {24'h0, o_err_cnt}, 32'h0);

      // directed commands
      frame(8'h01, 8'h3C, 8'h3D); check_all("write");
      chk("write.led_abs", {24'h0, led}, 32'h3C);
      frame(8'h02, 8'hC0, 8'hC2); check_all("set");
      chk("set.led_abs", {24'h0, led}, 32'hFC);
      frame(8'h03, 8'h0F, 8'h0C); check_all("clr");
      chk("clr.led_abs", {24'h0, led}, 32'hF0);
      frame(8'h04, 8'hFF, 8'hFB); check_all("toggle");
      chk("toggle.led_abs", {24'h0, led}, 32'h0F);
      frame(8'h01, 8'h55, 8'h00); check_all("bad_chk");
      chk("bad_chk.cnt_abs", {24'h0, o_err_cnt}, 32'd1);
      frame(8'h07, 8'h00, 8'h07); check_all("bad_cmd");
      chk("bad_cmd.cnt_abs", {24'h0, o_err_cnt}, 32'd2);

      // leading garbage, then SYNC value used as data
      send(8'h00, 3); send(8'h12, 3); send(8'hFF, 3);
      check_all("garbage");
      frame(8'h01, 8'hA5, 8'hA4); check_all("sync_as_data");
      chk("sync_as_data.led_abs", {24'h0, led}, 32'hA5);

      // mid-frame busy
      send(SYNC, 3);
      chk("busy_mid", {31'h0, o_busy}, 32'h1);
      send(8'h01, 3);

      // inter-byte timeout
      waited = 0;
      while (obs_to == exp_to && waited < TMO + 200) begin
         @(negedge clk);
         waited++;
      end
      chk("timeout.window", {31'h0, (waited >= TMO - 10 && waited <= TMO + 10)}, 32'h1);
      pos = 0; exp_to++; model_err();
      repeat (3) @(negedge clk);
      check_all("timeout");
      frame(8'h01, 8'h81, 8'h80); check_all("after_timeout");
      chk("after_timeout.led_abs", {24'h0, led}, 32'h81);

      // byte landing exactly on the last allowed cycle is accepted
      send(SYNC, TMO - 2);
      send(8'h04, 3); send(8'hFF, 3); send(8'hFB, 4);
      check_all("limit_byte_wins");

      // randomized frames
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            g = $urandom_range(0, 255);
            if (g == SYNC) g = 8'h5A;
            send(g, $urandom_range(3, 8));
         end
         c = $urandom_range(0, 5);
         d = $urandom_range(0, 255);
         k = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : (c ^ d);
         send(SYNC, $urandom_range(3, 8));
         send(c, $urandom_range(3, 8));
         send(d, $urandom_range(3, 8));
         send(k, $urandom_range(4, 8));
         check_all("random");
      end

      // reset mid-frame
      send(SYNC, 3); send(8'h01, 3);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      pos = 0; m_led = 8'h00; m_cnt = 0;
      repeat (2) @(negedge clk);
      check_all("mid_reset");

      // saturation
      for (int n = 0; n < 300; n++) begin
         send(SYNC, 3); send(8'h01, 3); send(8'h55, 3); send(8'h00, 3);
      end
      repeat (2) @(negedge clk);
      check_all("saturate");
      chk("saturate.cnt_abs", {24'h0, o_err_cnt}, 32'd255);
      chk("timeout_implies_err", obs_to_alone, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
